keypad_scan_ctrl: RTL
=====================

# keypad_scan_ctrl

Scan controller for the 4x4 matrix keypad. It drives one column at a time and samples the four row lines. It debounces a detected press in-line and emits a one-cycle key event carrying a 4-bit hex code. It sits between the keypad pins and the display/key-history logic, and sequences the row-debounce function per column instead of running one free-running debouncer per row.

## Interface
- SCAN_DWELL, 8: cycles each column is driven during scanning; legal range 4..255.
- DBNC_CYCLES, 16: consecutive stable cycles required to accept a press or a release; legal range 2..4095.
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- row_in  in  4  raw row lines, active-high when the key at (driven column, row) is closed; asynchronous to clk.
- col_out  out  4  one-hot active-high column drive.
- key_code  out  4  hex code of the last accepted key; holds its value between events.
- key_valid  out  1  one-cycle pulse; key_code is new on this cycle.
- key_held  out  1  high while an accepted key remains pressed.

## Operation
- row_in passes through a 2-flop synchronizer to give row_s. All decisions use row_s only.
- Reset values:
  - col_out = 4'b0001 (column index 0).
  - key_code = 4'h0.
  - key_valid = 0.
  - key_held = 0.
  - State = SCAN.
  - Dwell and debounce counters = 0.
  - Synchronizer flops = 0.
- SCAN state:
  - The dwell counter runs 0..SCAN_DWELL-1 for the current column.
  - Before the last dwell cycle: no action.
  - Last dwell cycle, row_s == 0: advance to column (idx+1) mod 4, wrapping 3 -> 0, and clear the dwell counter.
  - Last dwell cycle, row_s != 0: latch the column index and row_s pattern, hold col_out, clear the debounce counter, and go to DEBOUNCE.
- DEBOUNCE state:
  - row_s == latched pattern: increment the debounce counter.
  - row_s differs from the latched pattern (including 0): return to SCAN on the next column with no event.
  - Counter reaches DBNC_CYCLES-1 with a match, latched pattern one-hot: go to PRESSED.
  - Counter reaches DBNC_CYCLES-1 with a match, latched pattern has more than one bit set (ghost or chord): go to HOLD with no event.
- PRESSED state (exactly one cycle):
  - Register key_code from the (column, row) map.
  - Assert key_valid and key_held.
  - Go to HOLD.
- HOLD state:
  - Column stays frozen.
  - The debounce counter counts consecutive cycles with row_s == 0 and resets to 0 on any nonzero sample.
  - At DBNC_CYCLES-1: clear key_held and go to SCAN on the next column.
- Key map as [row][col 0..3]:
  - Row 0: 1 2 3 A.
  - Row 1: 4 5 6 B.
  - Row 2: 7 8 9 C.
  - Row 3: E 0 F D.
- Only one key is tracked at a time. A second key pressed during HOLD is ignored. HOLD exits only after all rows on the frozen column read 0.
- Synchronous rst asserted in any state, including mid-debounce or HOLD, returns all outputs and state to reset values on the next edge. No pending key_valid survives reset.

## Timing
- A row edge reaches row_s 2 cycles after row_in changes.
- Press latency: key_valid asserts DBNC_CYCLES+1 cycles after the SCAN-to-DEBOUNCE transition edge.
  - DBNC_CYCLES cycles are spent in DEBOUNCE.
  - The PRESSED output is registered.
- key_code and key_valid change on the same edge. key_held rises on that same edge.
- Release latency: key_held falls DBNC_CYCLES cycles after row_s first reads 0 and then stays 0.
- The worst-case scan period before a press is noticed is 4*SCAN_DWELL cycles.
- The synchronizer needs 3 cycles after a column change. The SCAN_DWELL >= 4 floor guarantees settled data at the last dwell cycle.

## Structure
- keypad_pkg holds:
  - The scan_state_t enum: SCAN, DEBOUNCE, PRESSED, HOLD.
  - The 16-entry key map constant.
  - A function returning the counter width, $clog2 of the max of SCAN_DWELL and DBNC_CYCLES.
- One sub-module, keypad_decode: combinational map of (2-bit column, one-hot row) to a 4-bit code plus a one_hot flag.
- The synchronizer and FSM live in keypad_scan_ctrl.

## Test plan
All scenarios run with SCAN_DWELL=8 and DBNC_CYCLES=16.

- Reset, no key:
  - col_out cycles 0001 -> 0010 -> 0100 -> 1000 -> 0001, each held exactly 8 cycles.
  - key_valid never asserts.
- Clean press of '5' (row 1 high only while column 1 is driven):
  - Exactly one key_valid pulse with key_code=4'h5.
  - key_held=1 until release.
  - After release, key_held falls 16 cycles after row_s reads 0, then scanning resumes at column 2.
- Bouncy press of 'D': row 3 toggles every 3 cycles for 40 cycles, then is stable.
  - Exactly one key_valid with key_code=4'hD, after stabilization.
  - No events during the bounce.
- Ghost: rows 0 and 2 both high on column 0 for 100 cycles.
  - No key_valid.
  - key_held stays 0.
  - Scanning resumes after 16 zero cycles.
- Second key during HOLD: '1' held, then row 2 asserted as well.
  - No second event until all rows clear and '7' is re-detected.
  - key_code changes 1 -> 7 only after the release.
- rst pulsed for 1 cycle mid-DEBOUNCE and mid-HOLD:
  - Next cycle shows col_out=0001, key_code=0, key_held=0, key_valid=0.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scan controller.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    HOLD     = 2'd3
  } scan_state_t;

  // Indexed by {row, col}: rows 0..3, columns 0..3.
  localparam logic [3:0] KEY_MAP [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'hE, 4'h0, 4'hF, 4'hD
  };

  function automatic int cnt_width(input int dwell, input int dbnc);
    int m;
    m = (dwell > dbnc) ? dwell : dbnc;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/keypad_decode.sv
// Combinational map of (column, row pattern) to a hex key code and a one-hot flag.
module keypad_decode
  import keypad_pkg::*;
(
  input  logic [1:0] col_idx,
  input  logic [3:0] row_pat,
  output logic [3:0] code,
  output logic       one_hot
);

  logic [1:0] row_idx;

  always_comb begin
    row_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (row_pat[i]) row_idx = i[1:0];
    end
    one_hot = (row_pat != 4'd0) && ((row_pat & (row_pat - 4'd1)) == 4'd0);
    code    = KEY_MAP[{row_idx, col_idx}];
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Column-scanning keypad controller with in-line press/release debounce and
// a one-cycle key event carrying the decoded hex code.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int SCAN_DWELL  = 8,
  parameter int DBNC_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int               CNT_W      = cnt_width(SCAN_DWELL, DBNC_CYCLES);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(SCAN_DWELL - 1);
  localparam logic [CNT_W-1:0] DBNC_LAST  = CNT_W'(DBNC_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  scan_state_t      state, state_nxt;
  logic [1:0]       col_idx, col_nxt;
  logic [CNT_W-1:0] dwell_cnt, dwell_nxt;
  logic [CNT_W-1:0] dbnc_cnt, dbnc_nxt;
  logic [3:0]       pat_lat, pat_nxt;
  logic [3:0]       row_p0, row_s;
  logic [3:0]       key_code_nxt;
  logic             key_valid_nxt, key_held_nxt;
  logic [3:0]       dec_code;
  logic             dec_one_hot;

  // The column index stays frozen outside SCAN, so it doubles as the latched column.
  keypad_decode u_decode (
    .col_idx (col_idx),
    .row_pat (pat_lat),
    .code    (dec_code),
    .one_hot (dec_one_hot)
  );

  assign col_out = 4'b0001 << col_idx;

  // Stage p0/p1: synchronizer, then state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      row_p0    <= 4'd0;
      row_s     <= 4'd0;
      state     <= SCAN;
      col_idx   <= 2'd0;
      dwell_cnt <= '0;
      dbnc_cnt  <= '0;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      row_p0    <= row_in;
      row_s     <= row_p0;
      state     <= state_nxt;
      col_idx   <= col_nxt;
      dwell_cnt <= dwell_nxt;
      dbnc_cnt  <= dbnc_nxt;
      key_code  <= key_code_nxt;
      key_valid <= key_valid_nxt;
      key_held  <= key_held_nxt;
    end
  end

  always_ff @(posedge clk) begin
    pat_lat <= pat_nxt;
  end

  always_comb begin
    state_nxt = state;
    col_nxt   = col_idx;
    dwell_nxt = dwell_cnt;
    dbnc_nxt  = dbnc_cnt;
    pat_nxt   = pat_lat;
    case (state)
      SCAN: begin
        if (dwell_cnt == DWELL_LAST) begin
          dwell_nxt = '0;
          if (row_s == 4'd0) begin
            col_nxt = col_idx + 2'd1;
          end else begin
            pat_nxt   = row_s;
            dbnc_nxt  = '0;
            state_nxt = DEBOUNCE;
          end
        end else begin
          dwell_nxt = dwell_cnt + CNT_ONE;
        end
      end
      DEBOUNCE: begin
        if (row_s != pat_lat) begin
          state_nxt = SCAN;
          col_nxt   = col_idx + 2'd1;
          dwell_nxt = '0;
        end else if (dbnc_cnt == DBNC_LAST) begin
          dbnc_nxt  = '0;
          // Multi-bit patterns are ghosts or chords: wait them out silently.
          state_nxt = dec_one_hot ? PRESSED : HOLD;
        end else begin
          dbnc_nxt = dbnc_cnt + CNT_ONE;
        end
      end
      PRESSED: begin
        dbnc_nxt  = '0;
        state_nxt = HOLD;
      end
      HOLD: begin
        if (row_s != 4'd0) begin
          dbnc_nxt = '0;
        end else if (dbnc_cnt == DBNC_LAST) begin
          dbnc_nxt  = '0;
          dwell_nxt = '0;
          col_nxt   = col_idx + 2'd1;
          state_nxt = SCAN;
        end else begin
          dbnc_nxt = dbnc_cnt + CNT_ONE;
        end
      end
      default: state_nxt = SCAN;
    endcase
  end

  always_comb begin
    key_valid_nxt = (state == PRESSED);
    key_held_nxt  = key_held;
    key_code_nxt  = key_code;
    if (state == PRESSED) begin
      key_held_nxt = 1'b1;
      key_code_nxt = dec_code;
    end else if (state == HOLD && row_s == 4'd0 && dbnc_cnt == DBNC_LAST) begin
      key_held_nxt = 1'b0;
    end
  end

endmodule
